uart_rx_frame_z: RTL and testbench

- UART receiver, the counterpart of the byte-sequenced transmitter path (8N1, LSB first).
- Synchronises the serial line, detects the start bit, samples each bit at its centre, checks the stop bit, and presents each received byte with a one-cycle valid strobe.
- Counts good bytes into fixed-length packets and pulses over_all when a packet completes. It sits at the board serial input and feeds the command/data consumer.

---
 rtl/uart_pkg_z.sv | 15 +
 rtl/rx_bps_gen_z.sv | 33 +++
 rtl/uart_rx_frame_z.sv | 115 +++++++++++
 tb/tb_uart_rx_frame_z.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg_z.sv
// Shared UART definitions for the RX and TX paths: frame states, data width
// and the default bit period.
package uart_pkg_z;

  localparam int DATA_BITS   = 8;
  localparam int BPS_CNT_DEF = 5208;  // 50 MHz / 9600 baud

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/rx_bps_gen_z.sv
// Receive bit-rate generator. Counts clk cycles within a bit period while
// enabled and strobes bps_mid at the centre of each bit.
module rx_bps_gen_z
  import uart_pkg_z::*;
#(
  parameter int BPS_CNT = BPS_CNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bps_start,
  output logic bps_mid
);

  localparam int CW = $clog2(BPS_CNT);

  logic [CW-1:0] bps_cnt;

  // Held at zero while idle so the first bit period starts aligned to the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bps_cnt <= '0;
    end else if (!bps_start) begin
      bps_cnt <= '0;
    end else if (bps_cnt == CW'(BPS_CNT - 1)) begin
      bps_cnt <= '0;
    end else begin
      bps_cnt <= bps_cnt + 1'b1;
    end
  end

  assign bps_mid = bps_start && (bps_cnt == CW'(BPS_CNT / 2 - 1));

endmodule

// File: rtl/uart_rx_frame_z.sv
// 8N1 UART receiver with packet counter. Synchronises RX232, samples each bit
// at its centre, checks the stop bit and strobes each good byte out.
// rx_valid is a one-cycle strobe with no back-pressure: the consumer must take
// data_rx in the cycle rx_valid is high (data_rx then holds until the next byte).
module uart_rx_frame_z
  import uart_pkg_z::*;
#(
  parameter int BPS_CNT = BPS_CNT_DEF,
  parameter int PKT_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX232,
  output logic [DATA_BITS-1:0] data_rx,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic                 over_all
);

  logic                 rx_s1, rx_s2, rx_s3;
  logic                 start_edge;
  logic                 bps_start;
  logic                 bps_mid;
  uart_state_t          state, next_state;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic [7:0]           pkt_cnt;

  // Two-flop synchroniser plus one delay flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= RX232;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign start_edge = rx_s3 & ~rx_s2;
  assign bps_start  = (state != ST_IDLE);
  assign busy       = bps_start;

  rx_bps_gen_z #(.BPS_CNT(BPS_CNT)) u_bps (
    .clk      (clk),
    .rst_n    (rst_n),
    .bps_start(bps_start),
    .bps_mid  (bps_mid)
  );

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; a start bit that is high at its centre was a glitch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start_edge) next_state = ST_START;
      ST_START: if (bps_mid) next_state = rx_s2 ? ST_IDLE : ST_DATA;
      ST_DATA:  if (bps_mid && bit_idx == 3'd7) next_state = ST_STOP;
      ST_STOP:  if (bps_mid) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Bit capture, output strobes and packet counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx   <= 3'd0;
      shift_reg <= '0;
      data_rx   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      over_all  <= 1'b0;
      pkt_cnt   <= 8'd0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      over_all  <= 1'b0;
      if (bps_mid) begin
        case (state)
          ST_START: bit_idx <= 3'd0;
          ST_DATA: begin
            shift_reg[bit_idx] <= rx_s2;
            bit_idx            <= bit_idx + 3'd1;
          end
          ST_STOP: begin
            if (rx_s2) begin
              data_rx  <= shift_reg;
              rx_valid <= 1'b1;
              if (pkt_cnt == 8'(PKT_LEN - 1)) begin
                over_all <= 1'b1;
                pkt_cnt  <= 8'd0;
              end else begin
                pkt_cnt <= pkt_cnt + 8'd1;
              end
            end else begin
              // Bad stop bit: drop the byte and the partial packet.
              frame_err <= 1'b1;
              pkt_cnt   <= 8'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_z.sv
// Directed bench for uart_rx_frame_z with a scoreboard of expected receive events.
module tb_uart_rx_frame_z;

  localparam int BPS = 16;
  localparam int PKT = 3;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_rx;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
  logic       over_all;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int valid_cyc = 0;
  int n_valid = 0;
  int n_err = 0;

  // Expected event: {is_frame_err, over_all, data_rx}
  logic [9:0] exp_q[$];
  int         pkt_m = 0;
  logic [7:0] last_m = 8'h00;

  uart_rx_frame_z #(.BPS_CNT(BPS), .PKT_LEN(PKT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX232    (rx),
    .data_rx  (data_rx),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy),
    .over_all (over_all)
  );

  // Clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard model updates.
  task automatic push_good(input logic [7:0] b);
    logic ov;
    pkt_m++;
    ov = (pkt_m == PKT);
    if (ov) pkt_m = 0;
    last_m = b;
    exp_q.push_back({1'b0, ov, b});
  endtask

  task automatic push_err();
    pkt_m = 0;
    exp_q.push_back({1'b1, 1'b0, last_m});
  endtask

  // Line drivers: each bit lasts BPS cycles, changing at the falling clock edge.
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    fall_cyc = cyc;
    hold(BPS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(BPS);
    end
    rx = stop_bit;
    hold(BPS);
  endtask

  // Output monitor: every strobe pops and compares one expected event.
  initial begin
    logic [9:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && (rx_valid || frame_err || over_all)) begin
        if (rx_valid) begin
          n_valid++;
          valid_cyc = cyc;
        end
        if (frame_err) n_err++;
        chk("strobe_exclusive", {30'd0, rx_valid, frame_err}, {30'd0, ~frame_err, frame_err});
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {22'd0, frame_err, over_all, data_rx}, 32'h3ff);
        end else begin
          e = exp_q.pop_front();
          chk("event", {22'd0, frame_err, over_all, data_rx}, {22'd0, e});
        end
      end
    end
  end

  // Directed sequence.
  initial begin
    int v0, e0, lat;
    rx    = 1'b1;
    rst_n = 1'b0;
    hold(3);
    #1;
    chk("reset_data", {24'd0, data_rx}, 32'h00);
    chk("reset_strobes", {29'd0, rx_valid, frame_err, over_all}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    hold(1);
    rst_n = 1'b1;
    hold(10);

    // Clean frame 8'hA5 with latency and busy checks.
    chk("idle_busy", {31'd0, busy}, 32'd0);
    v0 = n_valid;
    push_good(8'hA5);
    fork
      send_byte(8'hA5, 1'b1);
      begin
        hold(6);
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
      end
    join
    hold(2);
    chk("a5_valid_count", n_valid - v0, 32'd1);
    chk("a5_data", {24'd0, data_rx}, 32'hA5);
    chk("a5_busy_after", {31'd0, busy}, 32'd0);
    lat = valid_cyc - fall_cyc;
    chk("a5_latency_window", {31'd0, (lat >= 153 && lat <= 155)}, 32'd1);
    hold(20);

    // Short glitch on the idle line.
    v0 = n_valid;
    e0 = n_err;
    rx = 1'b0;
    hold(4);
    rx = 1'b1;
    hold(40);
    chk("glitch_no_valid", n_valid - v0, 32'd0);
    chk("glitch_no_err", n_err - e0, 32'd0);
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    chk("glitch_data", {24'd0, data_rx}, 32'hA5);

    // Bad stop bit.
    e0 = n_err;
    v0 = n_valid;
    push_err();
    send_byte(8'h3C, 1'b0);
    rx = 1'b1;
    hold(20);
    chk("stop_err_count", n_err - e0, 32'd1);
    chk("stop_err_no_valid", n_valid - v0, 32'd0);
    chk("stop_err_data", {24'd0, data_rx}, 32'hA5);
    chk("stop_err_pkt", {24'd0, dut.pkt_cnt}, 32'd0);

    // Three back-to-back frames complete a packet.
    v0 = n_valid;
    push_good(8'h01);
    push_good(8'h80);
    push_good(8'hFF);
    send_byte(8'h01, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'hFF, 1'b1);
    hold(20);
    chk("b2b_valid_count", n_valid - v0, 32'd3);
    chk("b2b_data", {24'd0, data_rx}, 32'hFF);
    chk("b2b_pkt", {24'd0, dut.pkt_cnt}, 32'd0);

    // Reset in the middle of DATA bit 4 of 8'h55.
    v0 = n_valid;
    rx = 1'b0;
    hold(BPS);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'h55 >> i);
      hold(BPS);
    end
    rx = 1'b1;
    hold(BPS / 2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_data", {24'd0, data_rx}, 32'h00);
    hold(4);
    rst_n = 1'b1;
    pkt_m = 0;
    last_m = 8'h00;
    hold(BPS * 8);
    chk("rst_mid_no_valid", n_valid - v0, 32'd0);
    push_good(8'h0F);
    send_byte(8'h0F, 1'b1);
    hold(20);
    chk("after_rst_data", {24'd0, data_rx}, 32'h0F);
    chk("after_rst_pkt", {24'd0, dut.pkt_cnt}, 32'd1);

    // Break: line low for 20 bit times.
    e0 = n_err;
    v0 = n_valid;
    push_err();
    rx = 1'b0;
    hold(BPS * 20);
    rx = 1'b1;
    hold(BPS * 2);
    chk("break_err_count", n_err - e0, 32'd1);
    chk("break_no_valid", n_valid - v0, 32'd0);
    chk("break_pkt", {24'd0, dut.pkt_cnt}, 32'd0);
    push_good(8'h42);
    send_byte(8'h42, 1'b1);
    hold(20);
    chk("break_then_valid", n_valid - v0, 32'd1);
    chk("break_then_data", {24'd0, data_rx}, 32'h42);

    // Everything expected must have been consumed within a bounded wait.
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) hold(1);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
